// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// UART transmit side of the serial link. Accepts one byte per write strobe
// and sends it on TxD as: start (0), 8 data bits LSB first, even parity,
// stop (1). Bit timing comes from a 16x baud tick derived from the 50 MHz
// system clock; the divider table matches the receiver so the two ends
// interoperate directly.
//
// Ports
//   clk          in   1  system clock, 50 MHz, rising edge
//   reset        in   1  asynchronous reset, active low
//   baud_select  in   3  baud rate select, latched when a frame is accepted
//   Tx_EN        in   1  transmitter enable; 0 idles / aborts a frame
//   Tx_WR        in   1  write strobe
//   Tx_DATA      in   8  byte to send, captured with Tx_WR
//   TxD          out  1  serial line, idle high (registered)
//   Tx_BUSY      out  1  high while a frame is in flight (registered)
// ---------------------------------------------------------------------------
module uart_transmitter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // 16x-oversampled divider for a 50 MHz clock; 10417 needs 14 bits.
  function automatic logic [13:0] divider(input logic [2:0] sel);
    logic [13:0] n;
    case (sel)
      3'b000:  n = 14'd10417; // 300
      3'b001:  n = 14'd2604;  // 1200
      3'b010:  n = 14'd651;   // 4800
      3'b011:  n = 14'd326;   // 9600
      3'b100:  n = 14'd163;   // 19200
      3'b101:  n = 14'd81;    // 38400
      3'b110:  n = 14'd54;    // 57600
      default: n = 14'd27;    // 115200
    endcase
    return n;
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  data_q;
  logic [2:0]  baud_q;
  logic [13:0] baud_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx, bit_nxt;
  logic        txd_q, busy_q;
  logic        txd_nxt, busy_nxt;

  logic [13:0] div_n;
  logic        accept;
  logic        baud_tick;
  logic        bit_done;
  logic        cnt_clear;

  // Divider comes from the latched select so a mid-frame change of
  // baud_select cannot stretch or shorten the bit in flight.
  assign div_n     = divider(baud_q);
  assign accept    = Tx_EN && Tx_WR && (state == S_IDLE);
  assign baud_tick = (baud_cnt == div_n - 14'd1);
  // 16th tick of the current bit: the edge on which the bit ends.
  assign bit_done  = baud_tick && (tick_cnt == 4'd15);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;

    case (state)
      S_IDLE: begin
        bit_nxt = 3'd0;
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        if (bit_done) begin
          state_nxt = S_DATA;
          bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      S_PARITY: begin
        if (bit_done) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Dropping the enable abandons any frame in flight.
    if (!Tx_EN && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      bit_nxt   = 3'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, so TxD/Tx_BUSY come straight out of
  // flops and change on the same edge as the state.
  // -------------------------------------------------------------------------
  always_comb begin
    txd_nxt  = 1'b1;
    busy_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   busy_nxt = 1'b0;
      S_START:  txd_nxt  = 1'b0;
      S_DATA:   txd_nxt  = data_q[bit_nxt];
      S_PARITY: txd_nxt  = ^data_q;  // even parity over data + parity bit
      S_STOP:   txd_nxt  = 1'b1;
      default: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Counters restart whenever a frame starts, ends or is aborted.
  assign cnt_clear = (state == S_IDLE) || (state_nxt == S_IDLE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_idx <= 3'd0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Frame latches: written only on acceptance, so a write while busy can
  // never corrupt the byte being shifted out.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= 8'd0;
      baud_q <= 3'd0;
    end else if (accept) begin
      data_q <= Tx_DATA;
      baud_q <= baud_select;
    end
  end

  // -------------------------------------------------------------------------
  // Baud divider (0..N-1) and 16-tick bit counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= 14'd0;
      tick_cnt <= 4'd0;
    end else if (cnt_clear) begin
      baud_cnt <= 14'd0;
      tick_cnt <= 4'd0;
    end else if (baud_tick) begin
      baud_cnt <= 14'd0;
      tick_cnt <= tick_cnt + 4'd1;  // wraps to 0 at the bit boundary
    end else begin
      baud_cnt <= baud_cnt + 14'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Registered line outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      txd_q  <= txd_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter. Bytes expected on the line are pushed
// to a scoreboard queue when written and popped when the frame is decoded
// from TxD. Inputs change on the falling clock edge (or #1 after the rising
// edge); outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int BIT_115K = 16 * 27;        // 432 cycles per bit
  localparam int FRAME_115K = 11 * BIT_115K; // 4752 cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       TxD;
  logic       Tx_BUSY;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  always #10 clk = ~clk;  // 50 MHz

  initial begin
    #1_990_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Drive a write; caller stands at a falling edge. Returns #1 after the
  // accepting edge. Tx_WR stays high when hold > 1 and is released by recv.
  task automatic write(input logic [7:0] d, input int hold, input bit expect_frame);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    if (expect_frame) sb.push_back(d);
    @(posedge clk);
    #1;
    if (hold <= 1) Tx_WR = 1'b0;
  endtask

  // Decode one 115200 frame starting in the cycle after acceptance.
  task automatic recv(input string name, input int hold, input int inject_at);
    logic [7:0]  exp_d;
    logic [7:0]  got_d;
    logic [10:0] exp_l;
    logic [10:0] got_l;
    int same;
    int busy_cnt;
    int c;
    chk({name, "_sb_nonempty"}, (sb.size() > 0), 1);
    exp_d = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    exp_l[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_l[i+1] = exp_d[i];
    exp_l[9]  = ^exp_d;
    exp_l[10] = 1'b1;
    got_l = '0;
    busy_cnt = 0;
    c = 0;
    for (int j = 0; j < 11; j++) begin
      same = 0;
      for (int b = 0; b < BIT_115K; b++) begin
        @(negedge clk);
        if (TxD === exp_l[j]) same++;
        if (Tx_BUSY === 1'b1) busy_cnt++;
        if (b == BIT_115K / 2) got_l[j] = TxD;
        if (hold > 1 && c == hold - 1) Tx_WR = 1'b0;
        if (inject_at >= 0 && c == inject_at) begin
          Tx_DATA = 8'h12;
          Tx_WR   = 1'b1;
        end
        if (inject_at >= 0 && c == inject_at + 1) Tx_WR = 1'b0;
        c++;
      end
      chk($sformatf("%s_bit%0d_len", name, j), same, BIT_115K);
    end
    for (int i = 0; i < 8; i++) got_d[i] = got_l[i+1];
    chk({name, "_start"},  got_l[0], 0);
    chk({name, "_data"},   got_d, exp_d);
    chk({name, "_parity"}, got_l[9], ^exp_d);
    chk({name, "_stop"},   got_l[10], 1);
    chk({name, "_busy_len"}, busy_cnt, FRAME_115K);
    @(negedge clk);
    chk({name, "_end_busy"}, Tx_BUSY, 0);
    chk({name, "_end_txd"},  TxD, 1);
  endtask

  // Baud table spot checks: length of the start bit of a 0x01 frame.
  logic [2:0] tbl_sel [4] = '{3'b011, 3'b100, 3'b101, 3'b110};
  int         tbl_n   [4] = '{326, 163, 81, 54};

  initial begin
    int cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd",  TxD, 1);
    chk("rst_busy", Tx_BUSY, 0);
    reset = 1'b1;
    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_txd", TxD, 1);

    // 0x85 at 115200
    baud_select = 3'b111;
    write(8'h85, 1, 1);
    recv("b85", 1, -1);

    // Parity cases
    write(8'h00, 1, 1); recv("b00", 1, -1);
    write(8'hFF, 1, 1); recv("bFF", 1, -1);
    write(8'h23, 1, 1); recv("b23", 1, -1);

    // Write while busy is ignored, then back-to-back on the busy fall
    write(8'hC4, 1, 1);
    recv("bC4", 1, 1000);
    write(8'h12, 1, 1);
    recv("b12", 1, -1);

    // Tx_WR held several cycles starts exactly one frame
    write(8'h5A, 4, 1);
    recv("b5A", 4, -1);
    repeat (5) @(negedge clk);
    chk("hold_no_second_busy", Tx_BUSY, 0);

    // Abort during D3 of 0xA7 (D3 = 0)
    write(8'hA7, 1, 0);
    repeat (4 * BIT_115K + 100) @(negedge clk);
    chk("abort_d3_level", TxD, 0);
    Tx_EN = 1'b0;
    @(negedge clk);
    chk("abort_txd",  TxD, 1);
    chk("abort_busy", Tx_BUSY, 0);
    Tx_EN = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", Tx_BUSY, 0);
    write(8'h3C, 1, 1);
    recv("b3C", 1, -1);

    // Reset during PARITY of 0x96 (parity 0)
    write(8'h96, 1, 0);
    repeat (9 * BIT_115K + 50) @(negedge clk);
    chk("pre_rst_parity", TxD, 0);
    chk("pre_rst_busy",   Tx_BUSY, 1);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_txd",  TxD, 1);
    chk("async_rst_busy", Tx_BUSY, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (TxD === 1'b1 && Tx_BUSY === 1'b0) cnt++;
    end
    chk("post_rst_idle", cnt, 20);
    write(8'hE1, 1, 1);
    recv("bE1", 1, -1);

    // Baud table: start bit lasts 16*N cycles
    for (int t = 0; t < 4; t++) begin
      baud_select = tbl_sel[t];
      write(8'h01, 1, 0);
      cnt = 0;
      for (int i = 0; i < 32 * tbl_n[t]; i++) begin
        @(negedge clk);
        if (TxD !== 1'b0) break;
        cnt++;
      end
      chk($sformatf("baud%0d_start_len", tbl_sel[t]), cnt, 16 * tbl_n[t]);
      Tx_EN = 1'b0;
      @(negedge clk);
      Tx_EN = 1'b1;
      @(negedge clk);
    end

    // 300 baud: start bit far outlasts any faster rate; mid-frame change of
    // baud_select to 111 must not shorten it.
    baud_select = 3'b000;
    write(8'h5A, 1, 0);
    cnt = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (i == 1000) baud_select = 3'b111;
      if (TxD === 1'b0 && Tx_BUSY === 1'b1) cnt++;
    end
    chk("b300_start_hold", cnt, 12000);
    Tx_EN = 1'b0;
    @(negedge clk);
    chk("b300_abort_txd", TxD, 1);
    Tx_EN = 1'b1;

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmit side of the serial link, the counterpart of the LED receiver path. Accepts one byte per write strobe and serialises it on TxD as start bit, 8 data bits LSB first, even parity bit and stop bit. Bit timing comes from an internal 16x baud-tick generator selected by `baud_select`, matching the receiver's baud table, so the two ends interoperate directly. Runs from the 50 MHz system clock.

## Interface

- No parameters. The clock is fixed at 50 MHz, and the divider table below is hard-coded.
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `baud_select`  in  3  baud rate select, latched at frame acceptance.
- `Tx_EN`  in  1  transmitter enable; 0 idles or aborts.
- `Tx_WR`  in  1  single-cycle write strobe.
- `Tx_DATA`  in  8  byte to send, captured with `Tx_WR`.
- `TxD`  out  1  serial line, idle high.
- `Tx_BUSY`  out  1  high while a frame is in flight.

## Operation

- **Baud table**: `baud_select` selects the divider N as follows.
  - 000 → 300 baud, N = 10417.
  - 001 → 1200 baud, N = 2604.
  - 010 → 4800 baud, N = 651.
  - 011 → 9600 baud, N = 326.
  - 100 → 19200 baud, N = 163.
  - 101 → 38400 baud, N = 81.
  - 110 → 57600 baud, N = 54.
  - 111 → 115200 baud, N = 27.
- **Baud counter**: counts 0..N-1 and asserts an internal tick when the count equals N-1. It then wraps to 0.
- **Bit length**: each bit lasts 16 ticks (16·N clk cycles), tracked by a 4-bit tick counter.
- **FSM states**:
  - IDLE: TxD=1, Tx_BUSY=0.
  - START: TxD=0.
  - DATA: TxD=data[i], i = 0..7, index held in a 3-bit counter.
  - PARITY: TxD = ^data (even parity: total ones over data+parity is even).
  - STOP: TxD=1.
- **Acceptance**: a write is accepted on an edge where Tx_EN=1, Tx_WR=1 and state=IDLE. On that edge:
  - Tx_DATA and baud_select are latched;
  - baud and tick counters clear;
  - state goes to START.
- **Transitions**: START→DATA(0)→…→DATA(7)→PARITY→STOP→IDLE. Each transition happens on the 16th tick of the current bit.
- **Ignored writes**: Tx_WR is ignored while Tx_BUSY=1 or Tx_EN=0. The latched data is never overwritten mid-frame.
- **Abort**: Tx_EN=0 in any non-IDLE state forces IDLE on the next edge (TxD=1, Tx_BUSY=0, counters cleared). The partial frame is abandoned.
- **Mid-frame baud change**: changing `baud_select` mid-frame has no effect until the next accepted write.
- **Reset**: asserting reset at any time immediately forces IDLE with TxD=1, Tx_BUSY=0, and all counters and latches at 0.

## Timing

- Reset values: TxD=1, Tx_BUSY=0, state IDLE.
- **Accepting edge k**: TxD=0 and Tx_BUSY=1 are both registered on edge k and visible after it.
- **Frame length**: the frame is 11 bit periods = 176·N cycles.
- **Bit boundaries**: bit j (start = 0, stop = 10) occupies cycles k+16·N·j through k+16·N·(j+1)-1.
- **End of frame**: Tx_BUSY falls on edge k+176·N, together with the return to IDLE. TxD is already 1 from the stop bit.
- **Back-to-back**: a Tx_WR on the edge where Tx_BUSY has just fallen (state IDLE) is accepted. This gives frames with no extra idle time.
- **Outputs**: TxD and Tx_BUSY are registered and glitch-free.
- **Tx_WR length**: Tx_WR held high for multiple cycles starts exactly one frame. The additional cycles fall while busy and are ignored.

## Test plan

- **0x85 at 115200**: baud_select=111, write 0x85.
  - TxD must be 0,1,0,1,0,0,0,0,1,1,1, each level held 432 cycles (8640 ns).
  - Tx_BUSY must stay high 4752 cycles.
  - Looping TxD into LED_receiver must display 85 with no PERROR/FERROR.
- **Parity**: write 0x00 → parity bit 0. Write 0xFF → parity bit 0. Write 0x23 → parity bit 1. Use baud 111 for all three.
- **Busy and back-to-back**:
  - Write 0xC4, then pulse Tx_WR with 0x12 at 1000 cycles into the frame → the second write is ignored and the frame carries 0xC4.
  - Write 0x12 on the cycle Tx_BUSY falls → accepted, with the start bit immediately following the stop bit.
- **Abort**: drop Tx_EN during D3 of a frame → next cycle TxD=1 and Tx_BUSY=0. A subsequent write with Tx_EN=1 sends a complete, correct frame.
- **Reset mid-frame**: pull reset low during PARITY → TxD=1 and Tx_BUSY=0 asynchronously (before the next clk edge), and remain so until writes resume.
- **Baud 300**: baud_select=000, write 0x5A → each bit lasts 166672 cycles. Switching baud_select to 111 mid-frame does not change the bit length.
